// File: rtl/rgb_pkg.sv
// Shared types and colour table for the tri-colour LED sequencer.
// Build macro RGB_SEQ_WHITE_EN adds WHITE (index 6) to the table.
package rgb_pkg;

   typedef enum logic [2:0] {
      RED     = 3'd0,
      YELLOW  = 3'd1,
      GREEN   = 3'd2,
      CYAN    = 3'd3,
      BLUE    = 3'd4,
      MAGENTA = 3'd5,
      WHITE   = 3'd6
   } color_t;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_t;

`ifdef RGB_SEQ_WHITE_EN
   localparam int NUM_COLORS = 7;
`else
   localparam int NUM_COLORS = 6;
`endif

   // Table index to {R,G,B}; indices outside the active table drive dark.
   function automatic logic [2:0] idx_to_color(input logic [2:0] idx);
      case (color_t'(idx))
         RED:     return 3'b100;
         YELLOW:  return 3'b110;
         GREEN:   return 3'b010;
         CYAN:    return 3'b011;
         BLUE:    return 3'b001;
         MAGENTA: return 3'b101;
`ifdef RGB_SEQ_WHITE_EN
         WHITE:   return 3'b111;
`endif
         default: return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Shared PWM stage: free-running counter, duty compare and registered LED drive.
// Table contents depend on RGB_SEQ_WHITE_EN only through the colour fed in.
module rgb_pwm
   import rgb_pkg::*;
#(
   parameter int PWM_BITS = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [PWM_BITS-1:0] duty,
   input  logic [2:0]          color,
   output logic [2:0]          out
);

   localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

   logic [PWM_BITS-1:0] pwm_cnt;
   logic                chan_en;

   // All-ones duty forces full-on so the top step reaches a true 100%.
   assign chan_en = (duty == '1) || (pwm_cnt < duty);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pwm_cnt <= '0;
         out     <= 3'b000;
      end else begin
         pwm_cnt <= pwm_cnt + CNT_ONE;
         out     <= chan_en ? color : 3'b000;
      end
   end

endmodule

// File: rtl/rgb_sequencer.sv
// Tri-colour LED sequencer: manual/auto colour stepping plus saturating brightness control.
// Define RGB_SEQ_WHITE_EN to extend the colour table with WHITE.
module rgb_sequencer
   import rgb_pkg::*;
#(
   parameter int PWM_BITS     = 8,
   parameter int AUTO_TICKS   = 1_000_000,
   parameter int DEFAULT_DUTY = 128,
   parameter int DUTY_STEP    = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       mode_toggle,
   input  logic       bright,
   input  logic       dim,
   output logic [2:0] out,
   output logic [2:0] color_idx,
   output logic       auto_mode
);

   localparam int DWELL_W = $clog2(AUTO_TICKS);

   localparam logic [DWELL_W-1:0]  DWELL_LAST   = DWELL_W'(AUTO_TICKS - 1);
   localparam logic [DWELL_W-1:0]  DWELL_ONE    = DWELL_W'(1);
   localparam logic [2:0]          IDX_LAST     = 3'(NUM_COLORS - 1);
   localparam logic [2:0]          IDX_ONE      = 3'd1;
   localparam logic [PWM_BITS:0]   STEP_EXT     = (PWM_BITS + 1)'(DUTY_STEP);
   localparam logic [PWM_BITS:0]   DUTY_MAX_EXT = {1'b0, {PWM_BITS{1'b1}}};
   localparam logic [PWM_BITS-1:0] DUTY_MAX     = '1;
   localparam logic [PWM_BITS-1:0] DUTY_RST     = PWM_BITS'(DEFAULT_DUTY);

   mode_t               mode, mode_nxt;
   logic [DWELL_W-1:0]  dwell, dwell_nxt;
   logic [2:0]          idx_nxt;
   logic [PWM_BITS-1:0] duty, duty_nxt;
   logic                dwell_term;
   logic                advance;
   logic [2:0]          color_bits;

   // One extra bit of headroom lets the sum/borrow show saturation without wrap.
   function automatic logic [PWM_BITS-1:0] duty_up(input logic [PWM_BITS-1:0] d);
      logic [PWM_BITS:0] sum;
      sum = {1'b0, d} + STEP_EXT;
      return (sum > DUTY_MAX_EXT) ? DUTY_MAX : sum[PWM_BITS-1:0];
   endfunction

   function automatic logic [PWM_BITS-1:0] duty_dn(input logic [PWM_BITS-1:0] d);
      logic [PWM_BITS:0] diff;
      diff = {1'b0, d} - STEP_EXT;
      return diff[PWM_BITS] ? '0 : diff[PWM_BITS-1:0];
   endfunction

   always_comb begin
      dwell_term = (mode == AUTO) && (dwell == DWELL_LAST);
      // A step landing on the terminal count still produces a single advance.
      advance    = step || dwell_term;

      idx_nxt = color_idx;
      if (advance) begin
         idx_nxt = (color_idx == IDX_LAST) ? 3'd0 : color_idx + IDX_ONE;
      end

      mode_nxt = mode;
      if (mode_toggle) begin
         mode_nxt = (mode == AUTO) ? MANUAL : AUTO;
      end

      dwell_nxt = dwell + DWELL_ONE;
      if ((mode_nxt == MANUAL) || mode_toggle || advance) begin
         dwell_nxt = '0;
      end

      duty_nxt = duty;
      if (bright && !dim) begin
         duty_nxt = duty_up(duty);
      end else if (dim && !bright) begin
         duty_nxt = duty_dn(duty);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         mode      <= MANUAL;
         dwell     <= '0;
         color_idx <= 3'd0;
         duty      <= DUTY_RST;
      end else begin
         mode      <= mode_nxt;
         dwell     <= dwell_nxt;
         color_idx <= idx_nxt;
         duty      <= duty_nxt;
      end
   end

   assign auto_mode  = (mode == AUTO);
   assign color_bits = idx_to_color(color_idx);

   rgb_pwm #(
      .PWM_BITS (PWM_BITS)
   ) u_pwm (
      .clk   (clk),
      .rst   (rst),
      .duty  (duty),
      .color (color_bits),
      .out   (out)
   );

endmodule
